// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed hex driver for a common-anode 7-segment display
//
// Purpose: shows a 16-bit value as four hex digits, one digit lit at a time.
// A load goes into a pending buffer and reaches the display only at a
// scan-frame boundary, so no digit changes part-way through a frame.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-low reset
//   data_in    in  16   value to display, taken when load=1
//   load       in   1   capture data_in this cycle
//   blank_lz   in   1   1 = blank leading-zero digits (sampled every cycle)
//   an         out  4   anode enables, active-low, an[0] = rightmost digit
//   seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point, active-low, always off
//   frame_done out  1   one-cycle pulse when a new frame starts on the outputs
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [15:0] CNT_MAX = 16'(REFRESH_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        first_q, first_d;
  logic        frame_done_q, frame_done_d;

  logic        tick;
  logic        boundary;
  logic [15:0] upper;
  logic [3:0]  nibble;
  logic        blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == 2'd3);

    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (boundary) begin
      // A load on the boundary itself bypasses the pending buffer.
      if (load) begin
        disp_d       = data_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        disp_d       = pend_q;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_d       = data_in;
      pend_valid_d = 1'b1;
    end

    // Digit idx is blanked when it and every digit to its left are zero.
    upper  = disp_q >> {idx_q, 2'b00};
    nibble = upper[3:0];
    blank  = blank_lz && (idx_q != 2'd0) && (upper == 16'd0);

    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'b1111111 : hex_to_seg(nibble);

    // Delayed one extra cycle so the pulse lines up with the first
    // registered output of digit 0 showing the newly committed value.
    first_d      = boundary;
    frame_done_d = first_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= 16'd0;
      idx_q        <= 2'd0;
      disp_q       <= 16'd0;
      pend_q       <= 16'd0;
      pend_valid_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      first_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      first_q      <= first_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  typedef struct {
    int          at_n;
    logic [15:0] val;
  } load_t;

  load_t       sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          n        = 0;
  logic [15:0] cur      = 16'h0000;

  function automatic logic [6:0] exp_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // One clock: inputs held across the edge, outputs checked 1 time unit later.
  task automatic cyc();
    logic        r, blz, ld;
    logic [15:0] dt, up;
    int          d;
    logic        blank;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    r = rst; blz = blank_lz; ld = load; dt = data_in;
    @(posedge clk);
    #1;
    if (!r) begin
      n = 0;
      sb.delete();
      cur = 16'h0000;
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_fd", 16'(frame_done), 16'h0);
    end else begin
      n++;
      if (ld) sb.push_back('{n, dt});
      // The edge before this one was a frame boundary: commit every load taken up to it.
      if (n > 1 && (n - 1) % FRAME == 0) begin
        while (sb.size() > 0 && sb[0].at_n <= n - 1) begin
          load_t e;
          e = sb.pop_front();
          cur = e.val;
        end
      end
      d     = ((n - 1) / D) % 4;
      up    = cur >> (4 * d);
      blank = blz && (d != 0) && (up == 16'h0000);
      e_an  = blank ? 4'b1111 : ~(4'b0001 << d);
      e_seg = blank ? 7'b1111111 : exp_seg(up[3:0]);
      chk("an", 16'(an), 16'(e_an));
      chk("seg", 16'(seg), 16'(e_seg));
      chk("frame_done", 16'(frame_done), 16'((n > 1 && (n - 1) % FRAME == 0) ? 1 : 0));
    end
    chk("dp", 16'(dp), 16'h1);
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < FRAME && (n % FRAME) != p; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    data_in = v;
    cyc();
    load = 1'b0;
    data_in = 16'h0000;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; data_in = 16'h0000; blank_lz = 1'b0;

    // Reset and free-running scan of value 0.
    run(3);
    rst = 1'b1;
    run(2 * FRAME + 4);

    // Load mid-frame, committed at the next boundary.
    to_phase(6);
    do_load(16'h1A3F);
    run(2 * FRAME);

    // Last load wins within a frame.
    to_phase(4);
    do_load(16'h1111);
    cyc();
    do_load(16'h2222);
    run(2 * FRAME);

    // Bypass: a load exactly on the boundary edge supersedes the pending value.
    to_phase(5);
    do_load(16'h5555);
    to_phase(FRAME - 1);
    do_load(16'hBEEF);
    run(2 * FRAME);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    to_phase(3);
    do_load(16'h0050);
    run(2 * FRAME);
    do_load(16'h0000);
    run(2 * FRAME);
    blank_lz = 1'b0;
    run(D + 2);
    blank_lz = 1'b1;
    do_load(16'h0A00);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // Reset mid-frame drops the pending value; a load during reset is ignored.
    to_phase(2);
    do_load(16'h1A3F);
    to_phase(5);
    do_load(16'h7777);
    rst = 1'b0;
    load = 1'b1;
    data_in = 16'h9999;
    cyc();
    rst = 1'b1;
    load = 1'b0;
    data_in = 16'h0000;
    run(3 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
